// File: rtl/scope_capture_core.sv
// scope_capture_core
//   Acquisition core for the oscilloscope datapath. Captures CH_NUM ADC
//   channels into a shared circular buffer with decimation and a
//   pre-trigger window. It uses an edge trigger with hysteresis and
//   supports auto, normal and single modes. A completed frame is held
//   until the consumer acknowledges it.
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   din, din_valid     packed channel samples (channel k at [k*DW +: DW])
//   dec_ratio          keep one of every dec_ratio+1 valid samples
//   trig_ch/level/hyst/edge/mode  trigger configuration
//   pre_trig           samples kept ahead of the trigger sample
//   arm, stop          start from IDLE / halt acquisition
//   frame_valid, frame_ack  frame handover handshake
//   trig_pos, trig_forced   physical trigger address, auto-timeout flag
//   busy               acquisition (PRE/WAIT/POST) in progress
//   rd_en, rd_addr, rd_data logical readout, 0 = oldest sample of frame
module scope_capture_core #(
  parameter int CH_NUM  = 2,
  parameter int DW      = 8,
  parameter int DEPTH   = 2048,
  parameter int AW      = $clog2(DEPTH),
  parameter int CW      = 3,
  parameter int AUTO_TO = 4_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH_NUM*DW-1:0] din,
  input  logic                 din_valid,
  input  logic [15:0]          dec_ratio,
  input  logic [CW-1:0]        trig_ch,
  input  logic [DW-1:0]        trig_level,
  input  logic [DW-1:0]        trig_hyst,
  input  logic                 trig_edge,
  input  logic [1:0]           trig_mode,
  input  logic [AW-1:0]        pre_trig,
  input  logic                 arm,
  input  logic                 stop,
  output logic                 frame_valid,
  input  logic                 frame_ack,
  output logic [AW-1:0]        trig_pos,
  output logic                 trig_forced,
  output logic                 busy,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic [CH_NUM*DW-1:0] rd_data
);

  localparam int ACW = $clog2(AUTO_TO + 1);
  localparam logic [ACW-1:0] AUTO_LAST = ACW'(AUTO_TO - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT,
    ST_POST,
    ST_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     dec_cnt_q, dec_cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   pre_eff_q, pre_eff_d;
  logic [ACW-1:0]  auto_cnt_q, auto_cnt_d;
  logic            armed_q, armed_d;
  logic [AW-1:0]   trig_pos_q, trig_pos_d;
  logic            trig_forced_q, trig_forced_d;
  logic [CH_NUM*DW-1:0] rd_data_q;

  logic [CH_NUM*DW-1:0] mem [DEPTH];

  logic            keep;
  logic            wr_en;
  logic [DW-1:0]   trig_sample;
  logic [DW-1:0]   thr_lo;
  logic [DW:0]     thr_sum;
  logic [DW-1:0]   thr_hi;
  logic            arm_cond;
  logic            fire_cond;
  logic            fire;
  logic            timeout;
  logic [AW-1:0]   post_len;
  logic [AW-1:0]   rd_phys;

  // Decimation and trigger detector front end. A trig_ch beyond the
  // channel count falls back to channel 0 because the loop never matches.
  // pre_trig is AW bits wide, so it can never exceed DEPTH-1 and needs no
  // explicit clamp.
  always_comb begin
    keep      = din_valid && (dec_cnt_q >= dec_ratio);
    dec_cnt_d = dec_cnt_q;
    if (din_valid) begin
      dec_cnt_d = keep ? '0 : dec_cnt_q + 16'd1;
    end

    trig_sample = din[DW-1:0];
    for (int k = 0; k < CH_NUM; k++) begin
      if (int'(trig_ch) == k) begin
        trig_sample = din[k*DW +: DW];
      end
    end

    thr_lo    = (trig_level >= trig_hyst) ? trig_level - trig_hyst : '0;
    thr_sum   = {1'b0, trig_level} + {1'b0, trig_hyst};
    thr_hi    = thr_sum[DW] ? '1 : thr_sum[DW-1:0];
    arm_cond  = trig_edge ? (trig_sample > thr_hi) : (trig_sample < thr_lo);
    fire_cond = trig_edge ? (trig_sample <= trig_level) : (trig_sample >= trig_level);
    fire      = armed_q && fire_cond;
    timeout   = (trig_mode == 2'd0) && (auto_cnt_q == AUTO_LAST);

    post_len = AW'(DEPTH - 1) - pre_eff_q;
    rd_phys  = trig_pos_q - pre_eff_q + rd_addr;
    wr_en    = keep && !stop &&
               ((state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST));
  end

  // Next-state logic. The partial frame is abandoned on stop during
  // acquisition. In HOLD, stop only redirects the post-ack destination.
  // A real fire takes priority over the auto timeout on the same sample.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    cnt_d         = cnt_q;
    pre_eff_d     = pre_eff_q;
    auto_cnt_d    = auto_cnt_q;
    armed_d       = armed_q;
    trig_pos_d    = trig_pos_q;
    trig_forced_d = trig_forced_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!stop && (arm || (trig_mode != 2'd2))) begin
          state_d   = ST_PRE;
          pre_eff_d = pre_trig;
          cnt_d     = '0;
        end
      end
      ST_PRE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (pre_eff_q == '0) begin
          state_d    = ST_WAIT;
          armed_d    = 1'b0;
          auto_cnt_d = '0;
        end else if (keep) begin
          if (arm_cond) begin
            armed_d = 1'b1;
          end
          if (cnt_q + 1'b1 == pre_eff_q) begin
            state_d    = ST_WAIT;
            armed_d    = 1'b0;
            auto_cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (keep) begin
          if (fire || timeout) begin
            trig_pos_d    = wr_ptr_q;
            trig_forced_d = !fire;
            cnt_d         = '0;
            state_d       = (post_len == '0) ? ST_HOLD : ST_POST;
            if (fire) begin
              armed_d = 1'b0;
            end
          end else begin
            if (arm_cond) begin
              armed_d = 1'b1;
            end
            if (auto_cnt_q != AUTO_LAST) begin
              auto_cnt_d = auto_cnt_q + 1'b1;
            end
          end
        end
      end
      ST_POST: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (keep) begin
          if (cnt_q + 1'b1 == post_len) begin
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (frame_ack) begin
          if (stop || (trig_mode == 2'd2)) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_PRE;
            pre_eff_d = pre_trig;
            cnt_d     = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      dec_cnt_q     <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      pre_eff_q     <= '0;
      auto_cnt_q    <= '0;
      armed_q       <= 1'b0;
      trig_pos_q    <= '0;
      trig_forced_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dec_cnt_q     <= dec_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      pre_eff_q     <= pre_eff_d;
      auto_cnt_q    <= auto_cnt_d;
      armed_q       <= armed_d;
      trig_pos_q    <= trig_pos_d;
      trig_forced_q <= trig_forced_d;
    end
  end

  // Sample buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // Registered read port, held while rd_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_phys];
    end
  end

  assign frame_valid = (state_q == ST_HOLD);
  assign busy        = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
  assign trig_pos    = trig_pos_q;
  assign trig_forced = trig_forced_q;
  assign rd_data     = rd_data_q;

endmodule
